// File: rtl/mem_arbiter.sv
// Two-port memory arbiter (CPU / loader) with fixed two-cycle accesses and a turnaround cycle.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break; otherwise the loader wins ties.
module mem_arbiter #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 CPU_Req,
  input  logic                 CPU_Wr,
  input  logic [AddrWidth-1:0] CPU_Addr,
  input  logic [DataWidth-1:0] CPU_DIn,
  output logic                 CPU_Gnt,
  output logic                 CPU_Done,
  output logic [DataWidth-1:0] CPU_DOut,
  input  logic                 LDR_Req,
  input  logic                 LDR_Wr,
  input  logic [AddrWidth-1:0] LDR_Addr,
  input  logic [DataWidth-1:0] LDR_DIn,
  output logic                 LDR_Gnt,
  output logic                 LDR_Done,
  output logic [DataWidth-1:0] LDR_DOut,
  output logic                 MEM_En,
  output logic                 MEM_Wr,
  output logic [AddrWidth-1:0] MEM_Addr,
  output logic [DataWidth-1:0] MEM_DOut,
  input  logic [DataWidth-1:0] MEM_DIn
);
  typedef enum logic [1:0] {S_Idle, S_Access, S_Done} state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;   // 1 = loader; doubles as the last-owner pointer
  logic                 mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0] mem_dout_q, mem_dout_d;
  logic                 cpu_gnt_q, cpu_gnt_d, ldr_gnt_q, ldr_gnt_d;
  logic                 cpu_done_q, cpu_done_d, ldr_done_q, ldr_done_d;
  logic [DataWidth-1:0] cpu_dout_q, cpu_dout_d, ldr_dout_q, ldr_dout_d;
  logic                 pick_ldr;

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_ldr = LDR_Req & (~CPU_Req | ~owner_q);
`else
  assign pick_ldr = LDR_Req;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    mem_en_d   = mem_en_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_dout_d = mem_dout_q;
    cpu_gnt_d  = cpu_gnt_q;
    ldr_gnt_d  = ldr_gnt_q;
    cpu_done_d = cpu_done_q;
    ldr_done_d = ldr_done_q;
    cpu_dout_d = cpu_dout_q;
    ldr_dout_d = ldr_dout_q;
    case (state_q)
      S_Idle: begin
        if (CPU_Req || LDR_Req) begin
          owner_d    = pick_ldr;
          mem_addr_d = pick_ldr ? LDR_Addr : CPU_Addr;
          mem_dout_d = pick_ldr ? LDR_DIn  : CPU_DIn;
          mem_wr_d   = pick_ldr ? LDR_Wr   : CPU_Wr;
          mem_en_d   = 1'b0;
          cpu_gnt_d  = ~pick_ldr;
          ldr_gnt_d  = pick_ldr;
          state_d    = S_Access;
        end else begin
          mem_en_d = 1'b1;
          mem_wr_d = 1'b1;
        end
      end
      S_Access: begin
        // Memory strobe is active-low: high means this access was a read.
        if (mem_wr_q) begin
          if (owner_q) ldr_dout_d = MEM_DIn;
          else         cpu_dout_d = MEM_DIn;
        end
        mem_en_d   = 1'b1;
        mem_wr_d   = 1'b1;
        cpu_done_d = ~owner_q;
        ldr_done_d = owner_q;
        state_d    = S_Done;
      end
      S_Done: begin
        cpu_done_d = 1'b0;
        ldr_done_d = 1'b0;
        cpu_gnt_d  = 1'b0;
        ldr_gnt_d  = 1'b0;
        state_d    = S_Idle;
      end
      default: state_d = S_Idle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_Idle;
      owner_q    <= 1'b0;
      mem_en_q   <= 1'b1;
      mem_wr_q   <= 1'b1;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      cpu_gnt_q  <= 1'b0;
      ldr_gnt_q  <= 1'b0;
      cpu_done_q <= 1'b0;
      ldr_done_q <= 1'b0;
      cpu_dout_q <= '0;
      ldr_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
      cpu_gnt_q  <= cpu_gnt_d;
      ldr_gnt_q  <= ldr_gnt_d;
      cpu_done_q <= cpu_done_d;
      ldr_done_q <= ldr_done_d;
      cpu_dout_q <= cpu_dout_d;
      ldr_dout_q <= ldr_dout_d;
    end
  end

  assign CPU_Gnt  = cpu_gnt_q;
  assign LDR_Gnt  = ldr_gnt_q;
  assign CPU_Done = cpu_done_q;
  assign LDR_Done = ldr_done_q;
  assign CPU_DOut = cpu_dout_q;
  assign LDR_DOut = ldr_dout_q;
  assign MEM_En   = mem_en_q;
  assign MEM_Wr   = mem_wr_q;
  assign MEM_Addr = mem_addr_q;
  assign MEM_DOut = mem_dout_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a negedge-acting memory model.
module tb_mem_arbiter;
  logic        Clk, Reset;
  logic        CPU_Req, CPU_Wr, CPU_Gnt, CPU_Done;
  logic [7:0]  CPU_Addr;
  logic [15:0] CPU_DIn, CPU_DOut;
  logic        LDR_Req, LDR_Wr, LDR_Gnt, LDR_Done;
  logic [7:0]  LDR_Addr;
  logic [15:0] LDR_DIn, LDR_DOut;
  logic        MEM_En, MEM_Wr;
  logic [7:0]  MEM_Addr;
  logic [15:0] MEM_DOut, mem_rd;
  logic [15:0] mem [256];

  int n_tot = 0;
  int n_bad = 0;

  mem_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .CPU_Req(CPU_Req), .CPU_Wr(CPU_Wr), .CPU_Addr(CPU_Addr), .CPU_DIn(CPU_DIn),
    .CPU_Gnt(CPU_Gnt), .CPU_Done(CPU_Done), .CPU_DOut(CPU_DOut),
    .LDR_Req(LDR_Req), .LDR_Wr(LDR_Wr), .LDR_Addr(LDR_Addr), .LDR_DIn(LDR_DIn),
    .LDR_Gnt(LDR_Gnt), .LDR_Done(LDR_Done), .LDR_DOut(LDR_DOut),
    .MEM_En(MEM_En), .MEM_Wr(MEM_Wr), .MEM_Addr(MEM_Addr), .MEM_DOut(MEM_DOut),
    .MEM_DIn(mem_rd)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (!MEM_En) begin
      if (!MEM_Wr) mem[MEM_Addr] <= MEM_DOut;
      else         mem_rd <= mem[MEM_Addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int ng, cgnt_hi, both_hi, ndone;
    logic [3:0] who;
    logic prev_c, prev_l;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1234;
    mem_rd = 16'h0000;
    Reset = 1'b0;
    CPU_Req = 1'b1; CPU_Wr = 1'b1; CPU_Addr = 8'h00; CPU_DIn = 16'h0000;
    LDR_Req = 1'b0; LDR_Wr = 1'b1; LDR_Addr = 8'h00; LDR_DIn = 16'h0000;

    tick(); tick();
    chk("rst_en", MEM_En, 1);
    chk("rst_wr", MEM_Wr, 1);
    chk("rst_addr", MEM_Addr, 0);
    chk("rst_mdout", MEM_DOut, 0);
    chk("rst_gnt", {CPU_Gnt, LDR_Gnt}, 0);
    chk("rst_done", {CPU_Done, LDR_Done}, 0);
    chk("rst_cdout", CPU_DOut, 0);
    chk("rst_ldout", LDR_DOut, 0);
    Reset = 1'b1;

    // CPU read of address 0
    tick();
    chk("rd_gnt", CPU_Gnt, 1);
    chk("rd_ldr_gnt", LDR_Gnt, 0);
    chk("rd_en", MEM_En, 0);
    chk("rd_wr", MEM_Wr, 1);
    tick();
    chk("rd_done", CPU_Done, 1);
    chk("rd_dout", CPU_DOut, 16'h1234);
    chk("rd_en_off", MEM_En, 1);
    CPU_Req = 1'b0;
    tick();
    chk("rd_gnt_off", CPU_Gnt, 0);
    chk("rd_done_off", CPU_Done, 0);

    // Loader write BEEF to address 4
    LDR_Req = 1'b1; LDR_Wr = 1'b0; LDR_Addr = 8'h04; LDR_DIn = 16'hBEEF;
    tick();
    chk("wr_gnt", LDR_Gnt, 1);
    chk("wr_cpu_gnt", CPU_Gnt, 0);
    chk("wr_mwr", MEM_Wr, 0);
    chk("wr_addr", MEM_Addr, 8'h04);
    chk("wr_mdout", MEM_DOut, 16'hBEEF);
    tick();
    chk("wr_mwr_off", MEM_Wr, 1);
    chk("wr_done", LDR_Done, 1);
    chk("wr_cpu_done", CPU_Done, 0);
    chk("wr_ldout", LDR_DOut, 0);
    LDR_Req = 1'b0; LDR_Wr = 1'b1;
    tick();
    chk("wr_done_off", LDR_Done, 0);

    // CPU reads back the loader's write
    CPU_Req = 1'b1; CPU_Addr = 8'h04;
    tick();
    chk("rb_gnt", CPU_Gnt, 1);
    tick();
    chk("rb_dout", CPU_DOut, 16'hBEEF);
    CPU_Req = 1'b0;
    tick();

    // Req dropped during access; address change after grant ignored
    CPU_Req = 1'b1; CPU_Addr = 8'h00;
    tick();
    chk("drop_gnt", CPU_Gnt, 1);
    CPU_Req = 1'b0; CPU_Addr = 8'h04;
    tick();
    chk("drop_done", CPU_Done, 1);
    chk("drop_dout", CPU_DOut, 16'h1234);
    chk("drop_addr", MEM_Addr, 8'h00);
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (CPU_Done || CPU_Gnt) ndone++;
    end
    chk("drop_no_second", ndone, 0);

    // Tie: both requesters held for four accesses
    CPU_Req = 1'b1; CPU_Addr = 8'h00;
    LDR_Req = 1'b1; LDR_Addr = 8'h04;
    ng = 0; cgnt_hi = 0; both_hi = 0; who = '0;
    prev_c = 1'b0; prev_l = 1'b0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      tick();
      if (CPU_Gnt && LDR_Gnt) both_hi++;
      if (CPU_Gnt) cgnt_hi++;
      if (LDR_Gnt && !prev_l) begin who[ng] = 1'b1; ng++; end
      else if (CPU_Gnt && !prev_c) begin who[ng] = 1'b0; ng++; end
      prev_c = CPU_Gnt; prev_l = LDR_Gnt;
    end
    chk("tie_count", ng, 4);
    chk("tie_one_gnt", both_hi, 0);
`ifdef ARB_ROUND_ROBIN_EN
    chk("tie_order", who, 4'b0101);
`else
    chk("tie_order", who, 4'b1111);
    chk("tie_cpu_starved", cgnt_hi, 0);
`endif
    CPU_Req = 1'b0; LDR_Req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("tie_idle", {CPU_Gnt, LDR_Gnt}, 0);

    // Async reset in the middle of an access
    CPU_Req = 1'b1; CPU_Addr = 8'h00;
    tick();
    chk("ar_gnt", CPU_Gnt, 1);
    #2 Reset = 1'b0;
    #1;
    chk("ar_en", MEM_En, 1);
    chk("ar_gnt_off", CPU_Gnt, 0);
    chk("ar_dout", CPU_DOut, 0);
    CPU_Req = 1'b0;
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (CPU_Done || LDR_Done) ndone++;
    end
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (CPU_Done || LDR_Done) ndone++;
    end
    chk("ar_no_done", ndone, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
